// File: rtl/check_node_minsum_serial.sv
// Serial min-sum check node: accepts DEGREE LLRs and tracks min1/min2/idx1/sign parity,
// then emits DEGREE extrinsic LLRs, one per cycle. The input and output phases never overlap.
module check_node_minsum_serial #(
    parameter int LLR_BIT = 6,
    parameter int DEGREE  = 4,
    parameter int OFFSET  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LLR_BIT-1:0]         in_llr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LLR_BIT-1:0]         out_llr,
    output logic [$clog2(DEGREE)-1:0]  out_idx,
    output logic                       out_last
);
    localparam int                 IDXW  = $clog2(DEGREE);
    localparam logic [IDXW-1:0]    LAST  = IDXW'(DEGREE - 1);
    localparam logic [LLR_BIT-2:0] MAXM  = '1;
    localparam logic [LLR_BIT-2:0] OFF_M = (LLR_BIT-1)'(OFFSET);
    localparam logic [LLR_BIT-1:0] MOST_NEG = {1'b1, {(LLR_BIT-1){1'b0}}};

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     cnt_q, cnt_d;
    logic [LLR_BIT-2:0]  min1_q, min1_d, min2_q, min2_d;
    logic [IDXW-1:0]     idx1_q, idx1_d;
    logic                parity_q, parity_d;
    logic [DEGREE-1:0]   sgn_q, sgn_d;

    logic                s_in;
    logic [LLR_BIT-1:0]  neg_in;
    logic [LLR_BIT-2:0]  m_in;
    logic [LLR_BIT-2:0]  m_sel, m_off;
    logic [LLR_BIT-1:0]  m_ext, e_llr;
    logic                e_sgn;

    // Input magnitude, with the most negative code saturating to MAXM
    always_comb begin
        s_in   = in_llr[LLR_BIT-1];
        neg_in = -in_llr;
        if (!s_in)
            m_in = in_llr[LLR_BIT-2:0];
        else if (in_llr == MOST_NEG)
            m_in = MAXM;
        else
            m_in = neg_in[LLR_BIT-2:0];
    end

    always_comb begin
        m_sel = (cnt_q == idx1_q) ? min2_q : min1_q;
        m_off = (m_sel > OFF_M) ? (m_sel - OFF_M) : '0;
        m_ext = {1'b0, m_off};
        e_sgn = parity_q ^ sgn_q[cnt_q];
        e_llr = e_sgn ? -m_ext : m_ext;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx1_d   = idx1_q;
        parity_d = parity_q;
        sgn_d    = sgn_q;
        if (state_q == COLLECT) begin
            if (in_valid) begin
                sgn_d[cnt_q] = s_in;
                parity_d     = parity_q ^ s_in;
                if (m_in < min1_q) begin
                    min2_d = min1_q;
                    min1_d = m_in;
                    idx1_d = cnt_q;
                end else if (m_in < min2_q) begin
                    min2_d = m_in;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + IDXW'(1);
                end
            end
        end else if (out_ready) begin
            if (cnt_q == LAST) begin
                state_d  = COLLECT;
                cnt_d    = '0;
                min1_d   = MAXM;
                min2_d   = MAXM;
                idx1_d   = '0;
                parity_d = 1'b0;
                sgn_d    = '0;
            end else begin
                cnt_d = cnt_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            min1_q   <= MAXM;
            min2_q   <= MAXM;
            idx1_q   <= '0;
            parity_q <= 1'b0;
            sgn_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            min1_q   <= min1_d;
            min2_q   <= min2_d;
            idx1_q   <= idx1_d;
            parity_q <= parity_d;
            sgn_q    <= sgn_d;
        end
    end

    // Outputs decode directly from registered state; data is forced to zero when not valid
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == EMIT);
        out_llr   = out_valid ? e_llr : '0;
        out_idx   = out_valid ? cnt_q : '0;
        out_last  = out_valid && (cnt_q == LAST);
    end
endmodule

// File: tb/tb_check_node_minsum_serial.sv
// Bench for check_node_minsum_serial: two instances (OFFSET 0 and 1) share one stimulus stream
// and are compared against a leave-one-out min-sum model.
module tb_check_node_minsum_serial;
    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_llr;
    logic         out_ready;

    logic         in_ready0, out_valid0, out_last0;
    logic [W-1:0] out_llr0;
    logic [1:0]   out_idx0;
    logic         in_ready1, out_valid1, out_last1;
    logic [W-1:0] out_llr1;
    logic [1:0]   out_idx1;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] fr [D];

    always #5 clk = ~clk;

    check_node_minsum_serial #(.LLR_BIT(W), .DEGREE(D), .OFFSET(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_llr(in_llr),
        .out_valid(out_valid0), .out_ready(out_ready), .out_llr(out_llr0),
        .out_idx(out_idx0), .out_last(out_last0));

    check_node_minsum_serial #(.LLR_BIT(W), .DEGREE(D), .OFFSET(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_llr(in_llr),
        .out_valid(out_valid1), .out_ready(out_ready), .out_llr(out_llr1),
        .out_idx(out_idx1), .out_last(out_last1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Extrinsic message for edge k: min magnitude and xor of signs over every other edge
    function automatic logic [W-1:0] model(input int k, input int off);
        int v, mag, mn, res;
        bit sg;
        logic [W-1:0] r;
        mn = 1 << 30;
        sg = 1'b0;
        for (int j = 0; j < D; j++) begin
            if (j != k) begin
                v   = $signed(fr[j]);
                mag = (v < 0) ? -v : v;
                if (mag > 31) mag = 31;
                if (mag < mn) mn = mag;
                sg ^= (v < 0);
            end
        end
        mn  = (mn > off) ? mn - off : 0;
        res = sg ? -mn : mn;
        r   = res[W-1:0];
        return r;
    endfunction

    task automatic set_frame(input int a, input int b, input int c, input int d);
        logic [31:0] t;
        t = a; fr[0] = t[W-1:0];
        t = b; fr[1] = t[W-1:0];
        t = c; fr[2] = t[W-1:0];
        t = d; fr[3] = t[W-1:0];
    endtask

    // Called at a negedge with the unit in COLLECT; returns at the negedge after the last accept
    task automatic drive_inputs(input int max_gap, input bit hold_valid);
        for (int i = 0; i < D; i++) begin
            int g;
            g = $urandom_range(0, max_gap);
            in_valid = 1'b0;
            in_llr   = W'($urandom);
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_llr   = fr[i];
            chk("in_ready_collect", {31'b0, in_ready0}, 1);
            chk("out_valid_collect", {31'b0, out_valid0}, 0);
            @(negedge clk);
        end
        in_valid = hold_valid;
        in_llr   = W'($urandom);
    endtask

    task automatic check_outputs(input int n_edges, input int stall_k, input int stall_n,
                                 input int max_rand_stall);
        for (int k = 0; k < n_edges; k++) begin
            int ns;
            ns = (k == stall_k) ? stall_n : $urandom_range(0, max_rand_stall);
            out_ready = 1'b0;
            for (int s = 0; s <= ns; s++) begin
                if (s == ns) out_ready = 1'b1;
                chk("out_valid", {31'b0, out_valid0}, 1);
                chk("out_valid_off1", {31'b0, out_valid1}, 1);
                chk("in_ready_emit", {31'b0, in_ready0}, 0);
                chk("out_idx", {30'b0, out_idx0}, k);
                chk("out_last", {31'b0, out_last0}, (k == D - 1) ? 1 : 0);
                chk("out_llr", {26'b0, out_llr0}, {26'b0, model(k, 0)});
                chk("out_llr_off1", {26'b0, out_llr1}, {26'b0, model(k, 1)});
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready0}, 1);
        chk({tag, "_out_valid"}, {31'b0, out_valid0}, 0);
        chk({tag, "_out_llr"}, {26'b0, out_llr0}, 0);
        chk({tag, "_out_idx"}, {30'b0, out_idx0}, 0);
        chk({tag, "_out_last"}, {31'b0, out_last0}, 0);
    endtask

    task automatic run_frame(input int max_gap, input int max_stall);
        drive_inputs(max_gap, 1'b0);
        check_outputs(D, -1, 0, max_stall);
        check_idle("post_frame");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_llr = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: min1=3 at edge 1, min2=5
        set_frame(5, -3, 7, -10);
        run_frame(0, 0);

        // Most negative code saturates to 31
        set_frame(-32, -32, -32, -32);
        run_frame(0, 0);

        // Tie on magnitude 4
        set_frame(4, -4, 6, 8);
        run_frame(0, 0);

        // Offset instance drives small magnitudes to zero
        set_frame(1, 2, 3, 4);
        run_frame(0, 0);

        // Stall 3 cycles on edge 2 while in_valid stays high through EMIT
        set_frame(5, -3, 7, -10);
        drive_inputs(0, 1'b1);
        check_outputs(D, 2, 3, 0);
        check_idle("post_stall");
        set_frame(-7, 2, 9, -1);
        run_frame(0, 0);

        // Asynchronous reset in the middle of EMIT
        set_frame(5, -3, 7, -10);
        drive_inputs(0, 1'b0);
        check_outputs(2, -1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid0}, 0);
        chk("rst_mid_in_ready", {31'b0, in_ready0}, 1);
        @(negedge clk);
        rst = 1'b0;
        check_idle("after_rst");
        run_frame(0, 0);

        // Random frames with input gaps and output stalls
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < D; i++) fr[i] = W'($urandom);
            if (f % 8 == 0) fr[$urandom_range(0, D - 1)] = 6'b100000;
            run_frame(3, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
